// File: rtl/ps2_key_decoder_if.sv
// Byte-stream and character-stream signals between Ps2Interface, the decoder
// and the character-buffer writer.
interface ps2_key_decoder_if;
    logic [7:0] rx_data;
    logic       read_data;
    logic       err;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output rx_data, read_data, err, char_ready,
        input  char_out, char_valid
    );

    modport slave (
        input  rx_data, read_data, err, char_ready,
        output char_out, char_valid
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Set-2 scancode to ASCII decoder: prefix FSM (F0/E0), Shift/Caps tracking,
// and a small character FIFO drained with a valid/ready handshake.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    ps2_key_decoder_if.slave kb,
    output logic             overflow,
    output logic             shift_active,
    output logic             caps_active,
    output logic [CNT_W-1:0] fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    state_t state, state_next;

    logic             lshift, rshift, caps_held;
    logic             accepted;
    logic             push, do_push, do_pop, full, empty;
    logic [7:0]       push_char;
    logic             lset, lclr, rset, rclr, caps_press, caps_rel;
    logic [9:0]       lut;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    // Result is {is_char, is_letter, ascii}; letters are returned lowercase.
    function automatic logic [9:0] lookup(input logic [7:0] sc);
        case (sc)
            8'h1C: lookup = 10'h361;  8'h32: lookup = 10'h362;  8'h21: lookup = 10'h363;
            8'h23: lookup = 10'h364;  8'h24: lookup = 10'h365;  8'h2B: lookup = 10'h366;
            8'h34: lookup = 10'h367;  8'h33: lookup = 10'h368;  8'h43: lookup = 10'h369;
            8'h3B: lookup = 10'h36A;  8'h42: lookup = 10'h36B;  8'h4B: lookup = 10'h36C;
            8'h3A: lookup = 10'h36D;  8'h31: lookup = 10'h36E;  8'h44: lookup = 10'h36F;
            8'h4D: lookup = 10'h370;  8'h15: lookup = 10'h371;  8'h2D: lookup = 10'h372;
            8'h1B: lookup = 10'h373;  8'h2C: lookup = 10'h374;  8'h3C: lookup = 10'h375;
            8'h2A: lookup = 10'h376;  8'h1D: lookup = 10'h377;  8'h22: lookup = 10'h378;
            8'h35: lookup = 10'h379;  8'h1A: lookup = 10'h37A;
            8'h45: lookup = 10'h230;  8'h16: lookup = 10'h231;  8'h1E: lookup = 10'h232;
            8'h26: lookup = 10'h233;  8'h25: lookup = 10'h234;  8'h2E: lookup = 10'h235;
            8'h36: lookup = 10'h236;  8'h3D: lookup = 10'h237;  8'h3E: lookup = 10'h238;
            8'h46: lookup = 10'h239;
            8'h29: lookup = 10'h220;  8'h5A: lookup = 10'h20D;  8'h66: lookup = 10'h208;
            default: lookup = 10'h000;
        endcase
    endfunction

    assign accepted     = kb.read_data & ~kb.err;
    assign lut          = lookup(kb.rx_data);
    assign shift_active = lshift | rshift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A frame error aborts any pending prefix.
    always_comb begin
        state_next = state;
        if (kb.read_data) begin
            if (kb.err) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (kb.rx_data == 8'hF0)      state_next = BRK;
                        else if (kb.rx_data == 8'hE0) state_next = EXT;
                    end
                    EXT:     state_next = (kb.rx_data == 8'hF0) ? EXT_BRK : IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        push       = 1'b0;
        push_char  = 8'h00;
        lset       = 1'b0;
        lclr       = 1'b0;
        rset       = 1'b0;
        rclr       = 1'b0;
        caps_press = 1'b0;
        caps_rel   = 1'b0;
        if (accepted && state == IDLE) begin
            case (kb.rx_data)
                8'h12:   lset = 1'b1;
                8'h59:   rset = 1'b1;
                8'h58:   caps_press = 1'b1;
                default: begin
                    push      = lut[9];
                    push_char = (lut[8] && (shift_active ^ caps_active)) ? lut[7:0] - 8'h20
                                                                        : lut[7:0];
                end
            endcase
        end else if (accepted && state == BRK) begin
            case (kb.rx_data)
                8'h12:   lclr = 1'b1;
                8'h59:   rclr = 1'b1;
                8'h58:   caps_rel = 1'b1;
                default: ;
            endcase
        end
    end

    // caps_held blocks typematic repeats of Caps Lock from re-toggling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lshift      <= 1'b0;
            rshift      <= 1'b0;
            caps_held   <= 1'b0;
            caps_active <= 1'b0;
        end else begin
            if (lset)      lshift <= 1'b1;
            else if (lclr) lshift <= 1'b0;
            if (rset)      rshift <= 1'b1;
            else if (rclr) rshift <= 1'b0;
            if (caps_press && !caps_held) caps_active <= ~caps_active;
            if (caps_press)    caps_held <= 1'b1;
            else if (caps_rel) caps_held <= 1'b0;
        end
    end

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = kb.char_ready & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_char;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    assign fifo_count    = count;
    assign kb.char_valid = ~empty;
    assign kb.char_out   = empty ? 8'h00 : mem[rd_ptr];
endmodule
